// File: rtl/mips_decls_p.sv
// Shared MIPS declarations: opcodes, fetch-stage state encoding and reset PC default.
`default_nettype none

package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic {
    IF_FETCH,
    IF_HOLD
  } ifetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/ifetch_pc_reg.sv
// Program counter with next-PC selection (sequential pc+4 or word-aligned redirect target).
`default_nettype none

module ifetch_pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcplus4
);

  logic [ADDR_W-1:0] w_next_pc;

  // Addition wraps naturally at 2^ADDR_W.
  assign pcplus4   = pc + ADDR_W'(4);
  assign w_next_pc = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : pcplus4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= w_next_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: requests words from a variable-latency imem port and holds them for decode.
// Optional performance counters are built when IFETCH_PERFCNT_EN is defined.
`default_nettype none

module ifetch_unit
  import mips_decls_p::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output opcode_t           opcode,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcplus4
`ifdef IFETCH_PERFCNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       wait_count
`endif
);

  ifetch_state_t r_state;
  logic          r_instr_valid;
  logic [31:0]   r_instr;
  logic          w_consume;

  assign w_consume = (r_state == IF_HOLD) && !stall;

  ifetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (w_consume),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pcplus4     (pcplus4)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IF_FETCH;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IF_FETCH: begin
          if (imem_ack) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= IF_HOLD;
          end
        end
        IF_HOLD: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
            r_state       <= IF_FETCH;
          end
        end
        default: r_state <= IF_FETCH;
      endcase
    end
  end

  // Gated with reset_n so the request drops the instant reset asserts.
  assign imem_req    = (r_state == IF_FETCH) && reset_n;
  assign imem_addr   = pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign opcode      = opcode_t'(r_instr[31:26]);

`ifdef IFETCH_PERFCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      wait_count  <= '0;
    end else begin
      if (w_consume) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if ((r_state == IF_FETCH) && !imem_ack) begin
        wait_count <= wait_count + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_ack_needs_req: assert property (@(posedge clk) disable iff (!reset_n) imem_ack |-> imem_req);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit with a program-order fetch model.
`default_nettype none

module tb_ifetch_unit;
  import mips_decls_p::*;

  localparam logic [31:0] RPC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  opcode_t     opcode;
  logic [31:0] pc;
  logic [31:0] pcplus4;
`ifdef IFETCH_PERFCNT_EN
  logic [31:0] fetch_count;
  logic [31:0] wait_count;
`endif

  ifetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .pcplus4     (pcplus4)
`ifdef IFETCH_PERFCNT_EN
    ,
    .fetch_count (fetch_count),
    .wait_count  (wait_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  int unsigned model_fetch = 0;
  int unsigned model_wait  = 0;
  bit          done = 1'b0;

  // Instruction memory contents; address 0 holds a lw.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples one step after each rising edge.
  initial begin
    logic        prev_valid;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [31:0] e;
    logic [31:0] w;
    int          idle;
    prev_valid = 1'b0;
    held_instr = '0;
    held_pc    = '0;
    idle       = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (!reset_n) begin
        prev_valid = 1'b0;
        idle = 0;
        continue;
      end
      if (imem_req) begin
        check32("valid_low_in_fetch", {31'b0, instr_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          check32("fetch_expected", 32'd0, 32'd1);
        end else begin
          check32("imem_addr", imem_addr, exp_q[0]);
        end
      end else begin
        check32("valid_high_in_hold", {31'b0, instr_valid}, 32'd1);
      end
      if (instr_valid && !prev_valid) begin
        idle = 0;
        if (exp_q.size() == 0) begin
          check32("capture_expected", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          w = mem_word(e);
          check32("instr", instr, w);
          check32("opcode", {26'b0, opcode}, {26'b0, w[31:26]});
          check32("pc", pc, e);
          check32("pcplus4", pcplus4, e + 32'd4);
        end
        held_instr = instr;
        held_pc    = pc;
      end else begin
        if (instr_valid) begin
          check32("instr_stable", instr, held_instr);
          check32("pc_stable", pc, held_pc);
        end
        idle++;
        if (idle > 40) begin
          check32("progress_timeout", 32'd0, 32'd1);
          idle = 0;
        end
      end
`ifdef IFETCH_PERFCNT_EN
      check32("fetch_count", fetch_count, model_fetch);
      check32("wait_count", wait_count, model_wait);
`endif
      prev_valid = instr_valid;
    end
  end

  // Driver: memory responder and downstream consumer, acting on the falling edge.
  initial begin
    int   wait_left;
    bit   req_active;
    int   stall_run;
    bit   first_consume;
    bit   did_reset;
    bit   release_pending;
    wait_left     = 0;
    req_active    = 1'b0;
    stall_run     = 0;
    first_consume = 1'b1;
    did_reset     = 1'b0;

    @(negedge clk);
    #1;
    check32("rst_req", {31'b0, imem_req}, 32'd0);
    check32("rst_valid", {31'b0, instr_valid}, 32'd0);
    check32("rst_pc", pc, RPC);
    check32("rst_instr", instr, 32'd0);
    model_pc = RPC;
    exp_q.push_back(model_pc);
    release_pending = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (release_pending) begin
        reset_n = 1'b1;
        release_pending = 1'b0;
      end
      #1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!req_active) begin
          req_active = 1'b1;
          wait_left  = $urandom_range(0, 3);
        end
        if (wait_left == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          req_active = 1'b0;
        end else begin
          wait_left--;
          model_wait++;
        end
      end

      redirect    = $urandom_range(0, 1) == 1;
      redirect_pc = $urandom;
      if (instr_valid) begin
        if (first_consume) begin
          stall    = 1'b0;
          redirect = 1'b0;
        end else begin
          stall = (stall_run < 6) && ($urandom_range(0, 1) == 1);
        end
        if (stall) begin
          stall_run++;
        end else begin
          stall_run     = 0;
          first_consume = 1'b0;
          model_fetch++;
          model_pc = redirect ? (redirect_pc & 32'hFFFF_FFFC) : (model_pc + 32'd4);
          exp_q.push_back(model_pc);
        end
      end else begin
        stall = $urandom_range(0, 1) == 1;
      end

      // One asynchronous reset in the middle of a memory wait.
      if (!did_reset && cyc > 400 && imem_req && !imem_ack) begin
        did_reset = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check32("async_req_drop", {31'b0, imem_req}, 32'd0);
        check32("async_valid_drop", {31'b0, instr_valid}, 32'd0);
        check32("async_pc", pc, RPC);
        exp_q.delete();
        model_pc = RPC;
        exp_q.push_back(model_pc);
        model_fetch     = 0;
        model_wait      = 0;
        req_active      = 1'b0;
        first_consume   = 1'b1;
        stall_run       = 0;
        stall           = 1'b1;
        redirect        = 1'b0;
        release_pending = 1'b1;
      end
    end

    @(negedge clk);
    imem_ack = 1'b0;
    done = 1'b1;
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Holds the PC and requests instructions from an instruction-memory port whose latency varies.
- Latches each returned word into an instruction register and presents it, with its opcode field, to decode.
- Advances or redirects the PC only when downstream accepts the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
ADDR_W, 32, PC/address width.

Ports:
clk  input  1  sole clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  ADDR_W  word-aligned fetch address.
imem_ack  input  1  read data valid; legal only in a cycle with imem_req=1, may arrive the same cycle.
imem_rdata  input  32  instruction word, valid with imem_ack.
stall  input  1  downstream not ready to consume the current instruction.
redirect  input  1  take redirect_pc as the next PC (branch taken / jump); sampled only on consume.
redirect_pc  input  ADDR_W  redirect target.
instr_valid  output  1  instr/opcode/pc hold a fetched instruction.
instr  output  32  instruction register.
opcode  output  mips_decls_p::opcode_t  instr[31:26], feeds maindec.
pc  output  ADDR_W  address of instr.
pcplus4  output  ADDR_W  pc + 4.

Behaviour:
- Reset (reset_n=0, any cycle, including mid-fetch):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0.
  - imem_req drops immediately; memory must discard any outstanding request.
- States:
  - FETCH:
    - imem_req=1, imem_addr=pc, instr_valid=0.
    - imem_ack=1: instr<=imem_rdata, instr_valid<=1, ->HOLD.
    - No ack: remain in FETCH with the address held stable.
  - HOLD:
    - imem_req=0, instr_valid=1, outputs stable.
    - stall=1: remain in HOLD.
    - stall=0 (consume): pc<=redirect ? {redirect_pc[ADDR_W-1:2],2'b00} : pc+4; instr_valid<=0; ->FETCH.
- Throughput and latency:
  - Zero-wait memory (ack same cycle as req) gives 1 instruction per 2 cycles.
  - Each wait cycle adds one cycle.
- Redirect:
  - Ignored in FETCH and in HOLD with stall=1.
  - redirect_pc[1:0] is discarded.
- Arithmetic:
  - pc+4 is modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0.
  - pcplus4 is combinational from pc.
- Gating: instr stays at its last value while instr_valid=0. Downstream must qualify regwrite/memwrite/branch/jump with instr_valid; opcode is not forced.
- Protocol violation: imem_ack with imem_req=0 is ignored and flagged by a simulation assertion.

Optional Feature:
- Macro IFETCH_PERFCNT_EN.
- Defined:
  - Output fetch_count[31:0] increments on each consume.
  - Output wait_count[31:0] increments on each FETCH cycle without ack.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- mips_decls_p gains:
  - typedef enum logic {IF_FETCH, IF_HOLD} ifetch_state_t;
  - localparam RESET_PC_DEFAULT.
  - Existing opcode_t is reused.
- One sub-module, ifetch_pc_reg:
  - PC register plus next-PC mux (pc+4 vs aligned redirect_pc).
  - Enable = consume, async active-low reset to RESET_PC.

Test Plan:
1. Reset, zero-wait memory returning 32'h8C08_0004 (lw) → imem_addr=0 in first cycle; next cycle instr_valid=1, opcode=OP_LW, pc=0, pcplus4=4.
2. Memory acks after 3 wait cycles → imem_addr held at 0x4 all 4 request cycles; instr_valid rises the cycle after ack; wait_count=3 when IFETCH_PERFCNT_EN is defined.
3. HOLD with stall=1 for 5 cycles, redirect toggling → instr, pc unchanged, imem_req=0; on stall=0 with redirect=0, next imem_addr=pc+4.
4. Consume with redirect=1, redirect_pc=32'h0000_0043 → next imem_addr=32'h0000_0040; redirect asserted during FETCH has no effect.
5. RESET_PC=32'hFFFF_FFFC, consume without redirect → next imem_addr=0.
6. reset_n pulsed low during a FETCH wait cycle → imem_req, instr_valid go 0 asynchronously; after release, imem_addr=RESET_PC and no stale ack is accepted.
